// File: rtl/read32_pattern_source.sv
// Synthetic FPGA-to-host 32-bit stream source for a Xillybus read channel.
// Emits a configurable deterministic word sequence per file-open session, with optional EOF and throttling.
module read32_pattern_source #(
    parameter int LEN_W = 16,
    parameter int GAP_W = 8
) (
    input  logic             bus_clk,
    input  logic             quiesce,
    input  logic [1:0]       cfg_mode,
    input  logic [31:0]      cfg_seed,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             user_r_rden,
    output logic             user_r_empty,
    output logic [31:0]      user_r_data,
    output logic             user_r_eof,
    input  logic             user_r_open,
    output logic [LEN_W-1:0] words_sent,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic             open_d_q;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] words_sent_q, words_sent_d;
    logic [31:0]      pat_q, pat_d;
    logic [31:0]      data_q, data_d;

    logic open_rise;
    logic accept;
    logic last_word;

    function automatic logic [31:0] next_pat(input logic [1:0] mode, input logic [31:0] p);
        logic [31:0] r;
        case (mode)
            2'd0:    r = p + 32'd1;
            2'd1:    r = p[0] ? ({1'b0, p[31:1]} ^ 32'h8020_0003) : {1'b0, p[31:1]};
            2'd2:    r = p;
            default: r = {p[30:0], p[31]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] first_pat(input logic [1:0] mode, input logic [31:0] seed);
        logic [31:0] r;
        case (mode)
            2'd1:    r = (seed == 32'd0) ? 32'd1 : seed;
            2'd3:    r = 32'd1 << seed[4:0];
            default: r = seed;
        endcase
        return r;
    endfunction

    assign open_rise = user_r_open & ~open_d_q;
    assign accept    = user_r_rden & (state_q == RUN);
    assign last_word = (len_q != '0) && ((cnt_q + LEN_W'(1)) == len_q);

    // open_d resets high so an open held across reset is not mistaken for a fresh open.
    always_ff @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) begin
            state_q      <= IDLE;
            open_d_q     <= 1'b1;
            mode_q       <= '0;
            len_q        <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            cnt_q        <= '0;
            words_sent_q <= '0;
            pat_q        <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            open_d_q     <= user_r_open;
            mode_q       <= mode_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            cnt_q        <= cnt_d;
            words_sent_q <= words_sent_d;
            pat_q        <= pat_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!user_r_open) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (open_rise) state_d = RUN;
                RUN: begin
                    if (accept) begin
                        if (last_word)           state_d = DONE;
                        else if (gap_q != '0)    state_d = GAP;
                    end
                end
                GAP:  if (gap_cnt_q <= GAP_W'(1)) state_d = RUN;
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: config shadowing on open, pattern/counter advance on each accepted read.
    always_comb begin
        mode_d       = mode_q;
        len_d        = len_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        cnt_d        = cnt_q;
        words_sent_d = words_sent_q;
        pat_d        = pat_q;
        data_d       = data_q;
        if ((state_q == IDLE) && open_rise) begin
            mode_d       = cfg_mode;
            len_d        = cfg_len;
            gap_d        = cfg_gap;
            pat_d        = first_pat(cfg_mode, cfg_seed);
            cnt_d        = '0;
            words_sent_d = '0;
        end
        if (accept) begin
            data_d    = pat_q;
            pat_d     = next_pat(mode_q, pat_q);
            cnt_d     = cnt_q + LEN_W'(1);
            gap_cnt_d = gap_q;
            if (words_sent_q != '1) words_sent_d = words_sent_q + LEN_W'(1);
        end
        if (state_q == GAP) gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end

    always_comb begin
        user_r_empty = (state_q != RUN);
        user_r_eof   = (state_q == DONE);
        busy         = (state_q == RUN) || (state_q == GAP);
    end

    assign user_r_data = data_q;
    assign words_sent  = words_sent_q;

endmodule
